// File: rtl/axis_eth_gen_pkg.sv
// Shared types and beat-formation helpers for the AXI-Stream Ethernet frame generator.
package axis_eth_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam int unsigned HDR_LEN = 14;
  localparam int unsigned MIN_LEN = 14;
  localparam int unsigned BEAT_W  = 11;

  function automatic logic [7:0] keep_from_rem(input logic [2:0] r);
    return (r == 3'd0) ? 8'hFF : 8'((9'd1 << r) - 9'd1);
  endfunction

  // hdr holds the 14 header bytes with the first byte on the wire in the MSBs.
  function automatic logic [63:0] build_beat(input logic [BEAT_W-1:0]    beat_idx,
                                             input logic [HDR_LEN*8-1:0] hdr,
                                             input logic [7:0]           frame_idx);
    logic [63:0] d;
    int unsigned n;
    logic [7:0]  k;
    d = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      n = 32'(beat_idx) * 32'd8 + j;
      if (n < HDR_LEN) begin
        d[8*j +: 8] = hdr[8*(HDR_LEN-1-n) +: 8];
      end else begin
        k           = 8'(n - HDR_LEN);
        d[8*j +: 8] = frame_idx + k;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/axis_eth_frame_gen.sv
// Ethernet frame generator driving the 64-bit AXI-Stream TX interface of the 10G MAC.
// Emits fixed-header, incrementing-payload frames with programmable count and gap.
module axis_eth_frame_gen
  import axis_eth_gen_pkg::*;
#(
  parameter int unsigned MAX_LEN = 9600,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [47:0]      cfg_dst_mac_i,
  input  logic [47:0]      cfg_src_mac_i,
  input  logic [15:0]      cfg_ethertype_i,
  input  logic [13:0]      cfg_len_i,
  input  logic [15:0]      cfg_count_i,
  input  logic [7:0]       cfg_gap_i,
  input  logic             cfg_err_i,
  output logic             m_axis_valid_o,
  output logic [63:0]      m_axis_data_o,
  output logic [7:0]       m_axis_keep_o,
  output logic             m_axis_eop_o,
  output logic             m_axis_err_o,
  input  logic             m_axis_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] frames_sent_o
);

  state_t                 state_q, state_d;
  logic [HDR_LEN*8-1:0]   hdr_q, hdr_d;
  logic [BEAT_W-1:0]      beats_m1_q, beats_m1_d;
  logic [2:0]             rem_q, rem_d;
  logic [15:0]            count_q, count_d;
  logic [7:0]             gap_q, gap_d;
  logic                   err_cfg_q, err_cfg_d;
  logic                   stop_q, stop_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [15:0]            frame_idx_q, frame_idx_d;
  logic [CNT_W-1:0]       frames_sent_q, frames_sent_d;
  logic                   valid_q, valid_d;
  logic [63:0]            data_q, data_d;
  logic [7:0]             keep_q, keep_d;
  logic                   eop_q, eop_d;
  logic                   uerr_q, uerr_d;

  logic                   load, clr, last;
  logic [BEAT_W-1:0]      load_beat;
  logic [15:0]            load_fidx;
  logic [13:0]            len_c;

  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    beats_m1_d    = beats_m1_q;
    rem_d         = rem_q;
    count_d       = count_q;
    gap_d         = gap_q;
    err_cfg_d     = err_cfg_q;
    stop_d        = stop_q;
    beat_d        = beat_q;
    gap_cnt_d     = gap_cnt_q;
    frame_idx_d   = frame_idx_q;
    frames_sent_d = frames_sent_q;
    valid_d       = valid_q;
    data_d        = data_q;
    keep_d        = keep_q;
    eop_d         = eop_q;
    uerr_d        = uerr_q;
    load          = 1'b0;
    clr           = 1'b0;
    last          = 1'b0;
    load_beat     = '0;
    load_fidx     = frame_idx_q;

    if (cfg_len_i < 14'(MIN_LEN))      len_c = 14'(MIN_LEN);
    else if (cfg_len_i > 14'(MAX_LEN)) len_c = 14'(MAX_LEN);
    else                               len_c = cfg_len_i;

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start_i) begin
          hdr_d         = {cfg_dst_mac_i, cfg_src_mac_i, cfg_ethertype_i};
          beats_m1_d    = BEAT_W'((len_c - 14'd1) >> 3);
          rem_d         = len_c[2:0];
          count_d       = cfg_count_i;
          gap_d         = cfg_gap_i;
          err_cfg_d     = cfg_err_i;
          stop_d        = stop_i;
          frame_idx_d   = '0;
          frames_sent_d = '0;
          state_d       = SEND;
          load          = 1'b1;
          load_fidx     = '0;
        end
      end
      SEND: begin
        stop_d = stop_q | stop_i;
        if (valid_q && m_axis_ready_i) begin
          if (eop_q) begin
            frames_sent_d = frames_sent_q + CNT_W'(1);
            frame_idx_d   = frame_idx_q + 16'd1;
            if (stop_d || (count_q != 16'd0 && frame_idx_d == count_q)) begin
              state_d = IDLE;
              stop_d  = 1'b0;
              clr     = 1'b1;
            end else if (gap_q == 8'd0) begin
              load      = 1'b1;
              load_fidx = frame_idx_d;
            end else begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
              clr       = 1'b1;
            end
          end else begin
            load      = 1'b1;
            load_beat = beat_q + BEAT_W'(1);
          end
        end
      end
      GAP: begin
        stop_d = stop_q | stop_i;
        if (stop_d) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end else if (gap_cnt_q == 8'd1) begin
          state_d = SEND;
          load    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Beat formation uses the _d config so the start cycle sees the freshly latched values.
    if (load) begin
      beat_d  = load_beat;
      last    = (load_beat == beats_m1_d);
      valid_d = 1'b1;
      keep_d  = last ? keep_from_rem(rem_d) : 8'hFF;
      data_d  = build_beat(load_beat, hdr_d, load_fidx[7:0]);
      for (int unsigned j = 0; j < 8; j++) begin
        if (!keep_d[j]) data_d[8*j +: 8] = '0;
      end
      eop_d  = last;
      uerr_d = last & err_cfg_d;
    end else if (clr) begin
      valid_d = 1'b0;
      data_d  = '0;
      keep_d  = '0;
      eop_d   = 1'b0;
      uerr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      hdr_q         <= '0;
      beats_m1_q    <= '0;
      rem_q         <= '0;
      count_q       <= '0;
      gap_q         <= '0;
      err_cfg_q     <= 1'b0;
      stop_q        <= 1'b0;
      beat_q        <= '0;
      gap_cnt_q     <= '0;
      frame_idx_q   <= '0;
      frames_sent_q <= '0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      keep_q        <= '0;
      eop_q         <= 1'b0;
      uerr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      beats_m1_q    <= beats_m1_d;
      rem_q         <= rem_d;
      count_q       <= count_d;
      gap_q         <= gap_d;
      err_cfg_q     <= err_cfg_d;
      stop_q        <= stop_d;
      beat_q        <= beat_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_idx_q   <= frame_idx_d;
      frames_sent_q <= frames_sent_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      keep_q        <= keep_d;
      eop_q         <= eop_d;
      uerr_q        <= uerr_d;
    end
  end

  assign m_axis_valid_o = valid_q;
  assign m_axis_data_o  = data_q;
  assign m_axis_keep_o  = keep_q;
  assign m_axis_eop_o   = eop_q;
  assign m_axis_err_o   = uerr_q;
  assign busy_o         = (state_q != IDLE);
  assign frames_sent_o  = frames_sent_q;

endmodule

// File: tb/tb_axis_eth_frame_gen.sv
// Scoreboard bench for axis_eth_frame_gen: expected beats are queued at stimulus time
// and a negedge monitor pops and compares each transferred beat.
`timescale 1ns/1ps
module tb_axis_eth_frame_gen;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        e;
    logic        u;
  } beat_t;

  localparam logic [47:0] DST = 48'hA1A2A3A4A5A6;
  localparam logic [47:0] SRC = 48'hB1B2B3B4B5B6;
  localparam logic [15:0] ET  = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0;
  logic [47:0] cfg_dst_mac_i = '0, cfg_src_mac_i = '0;
  logic [15:0] cfg_ethertype_i = '0, cfg_count_i = '0;
  logic [13:0] cfg_len_i = '0;
  logic [7:0]  cfg_gap_i = '0;
  logic        cfg_err_i = 1'b0;
  logic        m_axis_valid_o, m_axis_eop_o, m_axis_err_o, busy_o;
  logic [63:0] m_axis_data_o;
  logic [7:0]  m_axis_keep_o;
  logic        m_axis_ready_i = 1'b1;
  logic [31:0] frames_sent_o;

  always #5 clk = ~clk;

  axis_eth_frame_gen #(.MAX_LEN(9600), .CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .stop_i(stop_i),
    .cfg_dst_mac_i(cfg_dst_mac_i), .cfg_src_mac_i(cfg_src_mac_i),
    .cfg_ethertype_i(cfg_ethertype_i), .cfg_len_i(cfg_len_i),
    .cfg_count_i(cfg_count_i), .cfg_gap_i(cfg_gap_i), .cfg_err_i(cfg_err_i),
    .m_axis_valid_o(m_axis_valid_o), .m_axis_data_o(m_axis_data_o),
    .m_axis_keep_o(m_axis_keep_o), .m_axis_eop_o(m_axis_eop_o),
    .m_axis_err_o(m_axis_err_o), .m_axis_ready_i(m_axis_ready_i),
    .busy_o(busy_o), .frames_sent_o(frames_sent_o)
  );

  int    checks = 0, errors = 0;
  beat_t sb[$];
  int    gaps[$];
  bit    rand_ready = 1'b0;

  bit          pv, pr, in_frame, counting;
  beat_t       pb;
  int          gap_run, mon_frame, mon_beat;
  logic [7:0]  last_keep;
  logic [63:0] first_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model works byte by byte, then packs into 8-byte beats.
  task automatic push_frame(input logic [13:0] len, input logic [15:0] fidx, input bit err);
    int    L;
    logic [7:0] b;
    beat_t cur;
    L = (len < 14) ? 14 : ((len > 9600) ? 9600 : int'(len));
    cur = '0;
    for (int n = 0; n < L; n++) begin
      if (n < 6)       b = DST[47-8*n -: 8];
      else if (n < 12) b = SRC[47-8*(n-6) -: 8];
      else if (n < 14) b = ET[15-8*(n-12) -: 8];
      else             b = fidx[7:0] + 8'(n - 14);
      cur.d[8*(n%8) +: 8] = b;
      cur.k[n%8] = 1'b1;
      if ((n % 8) == 7 || n == L - 1) begin
        cur.e = (n == L - 1);
        cur.u = err && (n == L - 1);
        sb.push_back(cur);
        cur = '0;
      end
    end
  endtask

  task automatic start_run(input logic [13:0] len, input logic [15:0] cnt,
                           input logic [7:0] gap, input bit err);
    @(negedge clk);
    cfg_dst_mac_i = DST; cfg_src_mac_i = SRC; cfg_ethertype_i = ET;
    cfg_len_i = len; cfg_count_i = cnt; cfg_gap_i = gap; cfg_err_i = err;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cfg_dst_mac_i = '1; cfg_src_mac_i = 48'h123456789ABC; cfg_ethertype_i = 16'hDEAD;
    cfg_len_i = 14'd17; cfg_count_i = 16'd9; cfg_gap_i = 8'd0; cfg_err_i = ~err;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while (busy_o && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t cur, exp;
    cur = '{m_axis_data_o, m_axis_keep_o, m_axis_eop_o, m_axis_err_o};
    if (!rst_n) begin
      pv = 0; pr = 0; in_frame = 0; counting = 0; mon_frame = 0; mon_beat = 0;
    end else begin
      if (pv && !pr) chk("hold_stable", {m_axis_valid_o, cur}, {1'b1, pb});
      if (in_frame) chk("valid_mid_frame", m_axis_valid_o, 1'b1);
      if (!busy_o) begin
        counting = 0; mon_frame = 0; mon_beat = 0;
      end
      if (m_axis_valid_o) begin
        if (counting) begin
          gaps.push_back(gap_run);
          counting = 0;
        end
        if (m_axis_ready_i) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h expected=none", cur);
          end else begin
            exp = sb.pop_front();
            chk("beat", cur, exp);
          end
          if (mon_frame == 0 && mon_beat == 0) first_data = m_axis_data_o;
          if (m_axis_eop_o) begin
            last_keep = m_axis_keep_o;
            mon_frame++; mon_beat = 0; in_frame = 0; counting = 1; gap_run = 0;
          end else begin
            mon_beat++; in_frame = 1;
          end
        end
      end else if (counting) begin
        gap_run++;
      end
      pv = m_axis_valid_o; pr = m_axis_ready_i; pb = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    chk("reset_outputs", {m_axis_valid_o, m_axis_data_o, m_axis_keep_o, m_axis_eop_o,
                          m_axis_err_o, busy_o, frames_sent_o}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // len 60, single frame
    push_frame(14'd60, 16'd0, 1'b0);
    start_run(14'd60, 16'd1, 8'd0, 1'b0);
    chk("t1_busy", busy_o, 1'b1);
    wait_idle("t1_idle", 200);
    chk("t1_sent", frames_sent_o, 32'd1);
    chk("t1_last_keep", last_keep, 8'h0F);
    chk("t1_first_beat", first_data, 64'hB2B1A6A5A4A3A2A1);
    chk("t1_sb_empty", sb.size(), 0);

    // len 64, three frames, gap 4
    gaps.delete();
    for (int f = 0; f < 3; f++) push_frame(14'd64, 16'(f), 1'b0);
    start_run(14'd64, 16'd3, 8'd4, 1'b0);
    wait_idle("t2_idle", 300);
    chk("t2_sent", frames_sent_o, 32'd3);
    chk("t2_gap_count", gaps.size(), 2);
    chk("t2_gap0", gaps[0], 4);
    chk("t2_gap1", gaps[1], 4);
    chk("t2_last_keep", last_keep, 8'hFF);
    chk("t2_sb_empty", sb.size(), 0);

    // random backpressure, len 61
    rand_ready = 1'b1;
    for (int f = 0; f < 2; f++) push_frame(14'd61, 16'(f), 1'b0);
    start_run(14'd61, 16'd2, 8'd1, 1'b0);
    wait_idle("t3_idle", 1000);
    rand_ready = 1'b0;
    chk("t3_sent", frames_sent_o, 32'd2);
    chk("t3_last_keep", last_keep, 8'h1F);
    chk("t3_sb_empty", sb.size(), 0);

    // continuous run stopped during frame index 4
    for (int f = 0; f < 5; f++) push_frame(14'd40, 16'(f), 1'b0);
    start_run(14'd40, 16'd0, 8'd2, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(mon_frame == 4 && mon_beat == 3) && n < 2000);
    chk("t4_reached_frame4", n < 2000, 1'b1);
    stop_i = 1'b1;
    wait_idle("t4_idle", 200);
    stop_i = 1'b0;
    chk("t4_sent", frames_sent_o, 32'd5);
    chk("t4_sb_empty", sb.size(), 0);

    // short length with error flag
    push_frame(14'd10, 16'd0, 1'b1);
    start_run(14'd10, 16'd1, 8'd0, 1'b1);
    wait_idle("t5_idle", 100);
    chk("t5_sent", frames_sent_o, 32'd1);
    chk("t5_last_keep", last_keep, 8'h3F);
    chk("t5_sb_empty", sb.size(), 0);

    // reset mid-frame, then restart
    push_frame(14'd100, 16'd0, 1'b0);
    start_run(14'd100, 16'd1, 8'd0, 1'b0);
    n = 0;
    while (mon_beat < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {m_axis_valid_o, m_axis_data_o, m_axis_keep_o, m_axis_eop_o,
                             m_axis_err_o, busy_o, frames_sent_o}, '0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(14'd20, 16'd0, 1'b0);
    start_run(14'd20, 16'd1, 8'd0, 1'b0);
    wait_idle("t6_idle", 100);
    chk("t6_sent", frames_sent_o, 32'd1);
    chk("t6_first_beat", first_data, 64'hB2B1A6A5A4A3A2A1);
    chk("t6_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
